div_unit: RTL

- Sequential signed 32-bit divider for the multicycle MIPS datapath. It implements `div`.
- Sits upstream of the HI/LO select muxes. Its `DivHI` output drives the `B` input of the HI mux, and `DivLO` drives the `B` input of the LO mux.
- Operands come from the A/B operand registers. The control unit starts it and waits on `DivDone` before asserting `WriteHI`/`WriteLO`.
- Divide-by-zero is flagged so the control unit can take the exception path.

---
 rtl/div_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential signed restoring divider (HI=remainder, LO=quotient)
// Optional DIV_UNSIGNED_EN adds the DivUnsigned port for divu.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             DivStart,
`ifdef DIV_UNSIGNED_EN
    input  logic             DivUnsigned,
`endif
    input  logic [WIDTH-1:0] DivA,
    input  logic [WIDTH-1:0] DivB,
    output logic [WIDTH-1:0] DivHI,
    output logic [WIDTH-1:0] DivLO,
    output logic             DivBusy,
    output logic             DivDone,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;

    logic             signed_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] quo_shift;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~DivUnsigned;
`else
    assign signed_op = 1'b1;
`endif

    // Two's-complement magnitude; -2^(WIDTH-1) maps to its own bit pattern as unsigned.
    assign a_mag = (signed_op && DivA[WIDTH-1]) ? (~DivA + 1'b1) : DivA;
    assign b_mag = (signed_op && DivB[WIDTH-1]) ? (~DivB + 1'b1) : DivB;

    assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign quo_shift = {quo_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (DivStart) begin
                    if (DivB == '0) begin
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        cnt_d   = '0;
                        qsign_d = signed_op & (DivA[WIDTH-1] ^ DivB[WIDTH-1]);
                        rsign_d = signed_op & DivA[WIDTH-1];
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (rem_shift >= {1'b0, dvs_q}) begin
                    rem_d = rem_shift - {1'b0, dvs_q};
                    quo_d = quo_shift | {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    rem_d = rem_shift;
                    quo_d = quo_shift;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = qsign_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = rsign_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
        end
    end

    assign DivHI   = hi_q;
    assign DivLO   = lo_q;
    assign DivBusy = (state_q == RUN) || (state_q == FIX);
    assign DivDone = (state_q == DONE);
    assign DivZero = zero_q;

endmodule
